// File: rtl/rsq_pkg.sv
// Shared defaults, entry layout and oldest-ready encoder for the parametrised reservation queue.
// Optional flush port is enabled by defining RSQ_FLUSH_EN (see param_reservation_queue).
package rsq_pkg;

  localparam int RSQ_DEPTH     = 4;
  localparam int RSQ_DATA_W    = 32;
  localparam int RSQ_TAG_W     = 6;
  localparam int RSQ_FUNCT_W   = 3;
  localparam int RSQ_MAX_DEPTH = 64;

  typedef struct packed {
    logic                   valid;
    logic [RSQ_DATA_W-1:0]  op1_data;
    logic [RSQ_TAG_W-1:0]   op1_tag;
    logic                   op1_v;
    logic [RSQ_DATA_W-1:0]  op2_data;
    logic [RSQ_TAG_W-1:0]   op2_tag;
    logic                   op2_v;
    logic [RSQ_TAG_W-1:0]   rd_tag;
    logic [RSQ_FUNCT_W-1:0] funct;
  } rsq_entry_t;

  // Slot 0 is the oldest, so the lowest set bit wins; returns 0 when nothing is ready.
  function automatic int oldest_ready(input logic [RSQ_MAX_DEPTH-1:0] ready);
    int idx;
    idx = 0;
    for (int i = RSQ_MAX_DEPTH - 1; i >= 0; i--) begin
      if (ready[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/cdb_if.sv
// Common data bus broadcast: one tag/data result per cycle, snooped by reservation queues.
interface cdb_if #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 6
);
  logic              valid;
  logic [TAG_W-1:0]  tag;
  logic [DATA_W-1:0] data;

  modport producer (output valid, tag, data);
  modport consumer (input valid, tag, data);
endinterface

// File: rtl/rsq_slot.sv
// One reservation-queue entry: hold / shift-from-above / dispatch-write / clear, then CDB snoop.
module rsq_slot import rsq_pkg::*; #(
  parameter int  DATA_W  = RSQ_DATA_W,
  parameter int  TAG_W   = RSQ_TAG_W,
  parameter type entry_t = rsq_entry_t
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              write_en,
  input  logic              shift_en,
  input  entry_t            write_entry,
  input  entry_t            above_entry,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  output entry_t            entry
);

  entry_t src;
  entry_t nxt;

  // Snoop is applied to whatever lands here, so shifted and freshly dispatched entries never miss a wakeup.
  always_comb begin
    if (write_en)      src = write_entry;
    else if (shift_en) src = above_entry;
    else               src = entry;
    nxt = src;
    if (cdb_valid && src.valid) begin
      if (!src.op1_v && src.op1_tag == cdb_tag) begin
        nxt.op1_data = cdb_data;
        nxt.op1_v    = 1'b1;
      end
      if (!src.op2_v && src.op2_tag == cdb_tag) begin
        nxt.op2_data = cdb_data;
        nxt.op2_v    = 1'b1;
      end
    end
    if (clear) nxt = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) entry <= '0;
    else      entry <= nxt;
  end

endmodule

// File: rtl/param_reservation_queue.sv
// In-order-allocate, out-of-order-issue reservation queue with collapsing slots and CDB snoop.
// Define RSQ_FLUSH_EN to add a synchronous flush input that empties the queue.
module param_reservation_queue import rsq_pkg::*; #(
  parameter int DEPTH   = RSQ_DEPTH,
  parameter int DATA_W  = RSQ_DATA_W,
  parameter int TAG_W   = RSQ_TAG_W,
  parameter int FUNCT_W = RSQ_FUNCT_W
) (
  input  logic                         clk,
  input  logic                         rst,
`ifdef RSQ_FLUSH_EN
  input  logic                         flush,
`endif
  input  logic                         queue_en,
  input  logic [DATA_W-1:0]            op1_data_in,
  input  logic [TAG_W-1:0]             op1_tag_in,
  input  logic                         op1_valid_in,
  input  logic [DATA_W-1:0]            op2_data_in,
  input  logic [TAG_W-1:0]             op2_tag_in,
  input  logic                         op2_valid_in,
  input  logic [TAG_W-1:0]             rd_tag_in,
  input  logic [FUNCT_W-1:0]           funct_in,
  output logic                         queue_full,
  output logic [$clog2(DEPTH+1)-1:0]   queue_count,
  cdb_if.consumer                      cdb,
  output logic                         issue_valid,
  input  logic                         issue_ready,
  output logic [DATA_W-1:0]            op1_data_out,
  output logic [DATA_W-1:0]            op2_data_out,
  output logic [TAG_W-1:0]             rd_tag_out,
  output logic [FUNCT_W-1:0]           funct_out
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(DEPTH);

  typedef struct packed {
    logic               valid;
    logic [DATA_W-1:0]  op1_data;
    logic [TAG_W-1:0]   op1_tag;
    logic               op1_v;
    logic [DATA_W-1:0]  op2_data;
    logic [TAG_W-1:0]   op2_tag;
    logic               op2_v;
    logic [TAG_W-1:0]   rd_tag;
    logic [FUNCT_W-1:0] funct;
  } slot_t;

  if (DEPTH < 2 || DEPTH > RSQ_MAX_DEPTH) begin : g_bad_depth
    $error("param_reservation_queue: DEPTH out of range");
  end
  if ($bits(cdb.data) != DATA_W || $bits(cdb.tag) != TAG_W) begin : g_bad_cdb
    $error("param_reservation_queue: DATA_W/TAG_W do not match cdb_if");
  end

  slot_t            slots [DEPTH];
  slot_t            write_entry;
  logic [DEPTH-1:0] ready;
  logic [IDX_W-1:0] sel_idx;
  logic [CNT_W-1:0] count_q;
  logic             issue_fire;
  logic             dispatch;
  logic             flush_now;
  int               write_idx;

`ifdef RSQ_FLUSH_EN
  assign flush_now = flush;
`else
  assign flush_now = 1'b0;
`endif

  always_comb begin
    ready = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ready[i] = slots[i].valid && slots[i].op1_v && slots[i].op2_v;
    end
  end

  assign sel_idx     = IDX_W'(oldest_ready(RSQ_MAX_DEPTH'(ready)));
  assign issue_valid = |ready;
  assign issue_fire  = issue_valid && issue_ready;
  assign queue_full  = (count_q == CNT_W'(DEPTH));
  assign queue_count = count_q;
  assign dispatch    = queue_en && !queue_full;
  // A same-cycle issue collapses the queue by one, so the new entry lands one slot lower.
  assign write_idx   = int'(count_q) - (issue_fire ? 1 : 0);

  always_comb begin
    write_entry          = '0;
    write_entry.valid    = 1'b1;
    write_entry.op1_data = op1_data_in;
    write_entry.op1_tag  = op1_tag_in;
    write_entry.op1_v    = op1_valid_in;
    write_entry.op2_data = op2_data_in;
    write_entry.op2_tag  = op2_tag_in;
    write_entry.op2_v    = op2_valid_in;
    write_entry.rd_tag   = rd_tag_in;
    write_entry.funct    = funct_in;
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    slot_t above;
    if (i == DEPTH - 1) begin : g_top
      assign above = '0;
    end else begin : g_mid
      assign above = slots[i+1];
    end

    rsq_slot #(
      .DATA_W  (DATA_W),
      .TAG_W   (TAG_W),
      .entry_t (slot_t)
    ) u_slot (
      .clk         (clk),
      .rst         (rst),
      .clear       (flush_now),
      .write_en    (dispatch && (write_idx == i)),
      .shift_en    (issue_fire && (i >= int'(sel_idx))),
      .write_entry (write_entry),
      .above_entry (above),
      .cdb_valid   (cdb.valid),
      .cdb_tag     (cdb.tag),
      .cdb_data    (cdb.data),
      .entry       (slots[i])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                      count_q <= '0;
    else if (flush_now)            count_q <= '0;
    else if (dispatch && !issue_fire) count_q <= count_q + CNT_W'(1);
    else if (!dispatch && issue_fire) count_q <= count_q - CNT_W'(1);
  end

  always_comb begin
    op1_data_out = '0;
    op2_data_out = '0;
    rd_tag_out   = '0;
    funct_out    = '0;
    if (issue_valid) begin
      op1_data_out = slots[sel_idx].op1_data;
      op2_data_out = slots[sel_idx].op2_data;
      rd_tag_out   = slots[sel_idx].rd_tag;
      funct_out    = slots[sel_idx].funct;
    end
  end

endmodule

// File: tb/tb_param_reservation_queue.sv
// Directed self-checking bench for param_reservation_queue (default 4-entry configuration).
module tb_param_reservation_queue;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        queue_en;
  logic [31:0] op1_data_in;
  logic [5:0]  op1_tag_in;
  logic        op1_valid_in;
  logic [31:0] op2_data_in;
  logic [5:0]  op2_tag_in;
  logic        op2_valid_in;
  logic [5:0]  rd_tag_in;
  logic [2:0]  funct_in;
  logic        queue_full;
  logic [2:0]  queue_count;
  logic        issue_valid;
  logic        issue_ready;
  logic [31:0] op1_data_out;
  logic [31:0] op2_data_out;
  logic [5:0]  rd_tag_out;
  logic [2:0]  funct_out;

  int total = 0;
  int bad   = 0;

  cdb_if #(.DATA_W(32), .TAG_W(6)) cdb_bus ();

  param_reservation_queue #(
    .DEPTH(4), .DATA_W(32), .TAG_W(6), .FUNCT_W(3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
`ifdef RSQ_FLUSH_EN
    .flush        (flush),
`endif
    .queue_en     (queue_en),
    .op1_data_in  (op1_data_in),
    .op1_tag_in   (op1_tag_in),
    .op1_valid_in (op1_valid_in),
    .op2_data_in  (op2_data_in),
    .op2_tag_in   (op2_tag_in),
    .op2_valid_in (op2_valid_in),
    .rd_tag_in    (rd_tag_in),
    .funct_in     (funct_in),
    .queue_full   (queue_full),
    .queue_count  (queue_count),
    .cdb          (cdb_bus),
    .issue_valid  (issue_valid),
    .issue_ready  (issue_ready),
    .op1_data_out (op1_data_out),
    .op2_data_out (op2_data_out),
    .rd_tag_out   (rd_tag_out),
    .funct_out    (funct_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [31:0] d1, input logic [5:0] t1, input logic v1,
                                input logic [31:0] d2, input logic [5:0] t2, input logic v2,
                                input logic [5:0] rd, input logic [2:0] f);
    queue_en     = 1'b1;
    op1_data_in  = d1;
    op1_tag_in   = t1;
    op1_valid_in = v1;
    op2_data_in  = d2;
    op2_tag_in   = t2;
    op2_valid_in = v2;
    rd_tag_in    = rd;
    funct_in     = f;
  endtask

  task automatic set_cdb(input logic v, input logic [5:0] t, input logic [31:0] d);
    cdb_bus.valid = v;
    cdb_bus.tag   = t;
    cdb_bus.data  = d;
  endtask

  task automatic check_issue(input string tag, input logic [31:0] o1, input logic [31:0] o2,
                             input logic [5:0] rd, input logic [2:0] f);
    check_output({tag, "_valid"}, 32'(issue_valid), 32'd1);
    check_output({tag, "_op1"},   op1_data_out, o1);
    check_output({tag, "_op2"},   op2_data_out, o2);
    check_output({tag, "_rd"},    32'(rd_tag_out), 32'(rd));
    check_output({tag, "_funct"}, 32'(funct_out), 32'(f));
  endtask

  initial begin
    rst = 1'b0;
    flush = 1'b0;
    queue_en = 1'b0;
    issue_ready = 1'b0;
    apply_stimulus(32'h0, 6'd0, 1'b0, 32'h0, 6'd0, 1'b0, 6'd0, 3'd0);
    queue_en = 1'b0;
    set_cdb(1'b0, 6'd0, 32'h0);

    tick();
    tick();
    check_output("rst_count", 32'(queue_count), 32'd0);
    check_output("rst_full",  32'(queue_full), 32'd0);
    check_output("rst_valid", 32'(issue_valid), 32'd0);
    check_output("rst_op1",   op1_data_out, 32'd0);
    rst = 1'b1;
    tick();

    // single ready entry dispatched then issued
    apply_stimulus(32'd5, 6'd0, 1'b1, 32'd7, 6'd0, 1'b1, 6'd3, 3'd2);
    #1;
    check_output("t1_pre_valid", 32'(issue_valid), 32'd0);
    tick();
    queue_en = 1'b0;
    #1;
    check_issue("t1", 32'd5, 32'd7, 6'd3, 3'd2);
    check_output("t1_count1", 32'(queue_count), 32'd1);
    issue_ready = 1'b1;
    tick();
    #1;
    check_output("t1_count0", 32'(queue_count), 32'd0);
    check_output("t1_idle", 32'(issue_valid), 32'd0);
    check_output("t1_zero_rd", 32'(rd_tag_out), 32'd0);

    // fill with four entries waiting on op2 tags 10..13
    for (int k = 0; k < 4; k++) begin
      apply_stimulus(32'h100 + 32'(k), 6'd0, 1'b1, 32'h0, 6'(10 + k), 1'b0, 6'(20 + k), 3'(k));
      tick();
    end
    queue_en = 1'b0;
    #1;
    check_output("t2_count", 32'(queue_count), 32'd4);
    check_output("t2_full",  32'(queue_full), 32'd1);
    check_output("t2_valid", 32'(issue_valid), 32'd0);
    apply_stimulus(32'd1, 6'd0, 1'b1, 32'd1, 6'd0, 1'b1, 6'd63, 3'd7);
    tick();
    queue_en = 1'b0;
    #1;
    check_output("t2_ign_count", 32'(queue_count), 32'd4);
    check_output("t2_ign_valid", 32'(issue_valid), 32'd0);

    // wake slot 2 by CDB; it issues and slot 3 collapses down
    set_cdb(1'b1, 6'd12, 32'hAA);
    #1;
    check_output("t3_pre_valid", 32'(issue_valid), 32'd0);
    tick();
    set_cdb(1'b0, 6'd0, 32'h0);
    #1;
    check_issue("t3", 32'h102, 32'hAA, 6'd22, 3'd2);
    tick();
    #1;
    check_output("t3_count", 32'(queue_count), 32'd3);
    check_output("t3_full",  32'(queue_full), 32'd0);
    check_output("t3_idle",  32'(issue_valid), 32'd0);
    issue_ready = 1'b0;
    set_cdb(1'b1, 6'd13, 32'hBB);
    tick();
    set_cdb(1'b0, 6'd0, 32'h0);
    #1;
    check_issue("t3_shifted", 32'h103, 32'hBB, 6'd23, 3'd3);
    set_cdb(1'b1, 6'd10, 32'hCC);
    tick();
    set_cdb(1'b0, 6'd0, 32'h0);
    #1;
    check_issue("t3_older", 32'h100, 32'hCC, 6'd20, 3'd0);
    issue_ready = 1'b1;
    tick();
    #1;
    check_output("t3_cnt2", 32'(queue_count), 32'd2);
    check_output("t3_next_rd", 32'(rd_tag_out), 32'd23);
    tick();
    #1;
    check_output("t3_cnt1", 32'(queue_count), 32'd1);
    check_output("t3_left_idle", 32'(issue_valid), 32'd0);
    issue_ready = 1'b0;

    // dispatch-cycle capture of op1 from the CDB
    apply_stimulus(32'hDEAD, 6'd9, 1'b0, 32'h66, 6'd0, 1'b1, 6'd30, 3'd5);
    set_cdb(1'b1, 6'd9, 32'h55);
    tick();
    queue_en = 1'b0;
    set_cdb(1'b0, 6'd0, 32'h0);
    #1;
    check_issue("t4", 32'h55, 32'h66, 6'd30, 3'd5);
    check_output("t4_count", 32'(queue_count), 32'd2);

    // wake slot 0, then dispatch and issue in the same cycle
    set_cdb(1'b1, 6'd11, 32'h77);
    tick();
    set_cdb(1'b0, 6'd0, 32'h0);
    #1;
    check_issue("t5_pre", 32'h101, 32'h77, 6'd21, 3'd1);
    apply_stimulus(32'd1, 6'd0, 1'b1, 32'd2, 6'd0, 1'b1, 6'd40, 3'd6);
    issue_ready = 1'b1;
    tick();
    queue_en = 1'b0;
    issue_ready = 1'b0;
    #1;
    check_output("t5_count", 32'(queue_count), 32'd2);
    check_issue("t5_slot0", 32'h55, 32'h66, 6'd30, 3'd5);
    issue_ready = 1'b1;
    tick();
    #1;
    check_issue("t5_slot1", 32'd1, 32'd2, 6'd40, 3'd6);
    check_output("t5_cnt1", 32'(queue_count), 32'd1);
    tick();
    #1;
    check_output("t5_cnt0", 32'(queue_count), 32'd0);
    issue_ready = 1'b0;

    // both operands wait on the same tag and capture together
    apply_stimulus(32'h0, 6'd60, 1'b0, 32'h0, 6'd60, 1'b0, 6'd7, 3'd1);
    tick();
    queue_en = 1'b0;
    #1;
    check_output("t7_wait", 32'(issue_valid), 32'd0);
    set_cdb(1'b1, 6'd60, 32'h99);
    tick();
    set_cdb(1'b0, 6'd0, 32'h0);
    #1;
    check_issue("t7", 32'h99, 32'h99, 6'd7, 3'd1);
    issue_ready = 1'b1;
    tick();
    issue_ready = 1'b0;
    #1;
    check_output("t7_cnt0", 32'(queue_count), 32'd0);

`ifdef RSQ_FLUSH_EN
    for (int k = 0; k < 3; k++) begin
      apply_stimulus(32'h0, 6'(50 + k), 1'b0, 32'd1, 6'd0, 1'b1, 6'(k), 3'd0);
      tick();
    end
    queue_en = 1'b0;
    #1;
    check_output("t6_pre_count", 32'(queue_count), 32'd3);
    apply_stimulus(32'd3, 6'd0, 1'b1, 32'd4, 6'd0, 1'b1, 6'd44, 3'd4);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    queue_en = 1'b0;
    #1;
    check_output("t6_count", 32'(queue_count), 32'd0);
    check_output("t6_valid", 32'(issue_valid), 32'd0);
`endif

    // asynchronous reset in the middle of operation
    apply_stimulus(32'd8, 6'd0, 1'b1, 32'd9, 6'd0, 1'b1, 6'd12, 3'd3);
    tick();
    queue_en = 1'b0;
    #1;
    check_output("t8_valid", 32'(issue_valid), 32'd1);
    #1;
    rst = 1'b0;
    #1;
    check_output("t8_count", 32'(queue_count), 32'd0);
    check_output("t8_idle",  32'(issue_valid), 32'd0);
    rst = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
